// File: rtl/ram32x4_scan_master_pkg.sv
// Shared constants and state encoding for the 32x4 RAM scan master.
package ram32x4_scan_master_pkg;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 4;
  localparam int DEPTH  = 2 ** ADDR_W;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CLEAR    = 3'd1,
    ST_WRITE    = 3'd2,
    ST_RD_ISSUE = 3'd3,
    ST_RD_WAIT  = 3'd4,
    ST_DWELL    = 3'd5
  } state_t;

endpackage

// File: rtl/ram32x4_scan_master_scan_dwell_timer.sv
// Loadable down-counter. tc is high during the last cycle of a loaded
// interval, so loading N gives exactly N cycles before the owner leaves.
module scan_dwell_timer #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             tc
);

  logic [CNT_W-1:0] cnt;

  // Reload on request, otherwise count down and rest at zero
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign tc = (cnt == CNT_W'(1));

endmodule

// File: rtl/ram32x4_scan_master.sv
// Initiator for a registered-input 32x4 RAM: clear pass, single manual
// writes and an ordered scan that holds each location on disp_* for DWELL
// cycles. RD_LAT must be >= 2 and DWELL >= 1; every output is registered.
module ram32x4_scan_master
  import ram32x4_scan_master_pkg::*;
#(
  parameter int RD_LAT = 2,
  parameter int DWELL  = 50_000_000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_scan,
  input  logic              loop,
  input  logic              stop,
  input  logic              clear_req,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_write,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [ADDR_W-1:0] disp_addr,
  output logic [DATA_W-1:0] disp_data,
  output logic              disp_valid,
  output logic              busy,
  output logic              done
);

  localparam int                TMR_W      = $clog2(DWELL + 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(DEPTH - 1);
  localparam logic [TMR_W-1:0]  WAIT_LOAD  = TMR_W'(RD_LAT - 1);
  localparam logic [TMR_W-1:0]  DWELL_LOAD = TMR_W'(DWELL);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] ctr, ctr_nxt;
  logic [ADDR_W-1:0] ram_addr_nxt;
  logic [DATA_W-1:0] ram_wdata_nxt;
  logic              ram_write_nxt;
  logic [ADDR_W-1:0] disp_addr_nxt;
  logic [DATA_W-1:0] disp_data_nxt;
  logic              disp_valid_nxt;
  logic              done_nxt;
  logic              tmr_load;
  logic [TMR_W-1:0]  tmr_val;
  logic              tmr_tc;

  scan_dwell_timer #(
    .CNT_W (TMR_W)
  ) u_timer (
    .clk      (clk),
    .rst      (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .tc       (tmr_tc)
  );

  // Next state and next registered output values
  always_comb begin
    state_nxt      = state;
    ctr_nxt        = ctr;
    ram_addr_nxt   = ram_addr;
    ram_wdata_nxt  = ram_wdata;
    ram_write_nxt  = 1'b0;
    disp_addr_nxt  = disp_addr;
    disp_data_nxt  = disp_data;
    disp_valid_nxt = disp_valid;
    done_nxt       = 1'b0;
    tmr_load       = 1'b0;
    tmr_val        = '0;

    case (state)
      ST_IDLE: begin
        if (clear_req) begin
          state_nxt     = ST_CLEAR;
          ctr_nxt       = '0;
          ram_addr_nxt  = '0;
          ram_wdata_nxt = '0;
          ram_write_nxt = 1'b1;
        end else if (wr_req) begin
          state_nxt     = ST_WRITE;
          ram_addr_nxt  = wr_addr;
          ram_wdata_nxt = wr_data;
          ram_write_nxt = 1'b1;
        end else if (start_scan) begin
          state_nxt    = ST_RD_ISSUE;
          ctr_nxt      = '0;
          ram_addr_nxt = '0;
        end
      end

      ST_CLEAR: begin
        if (ctr == LAST_ADDR) begin
          state_nxt      = ST_IDLE;
          disp_valid_nxt = 1'b0;
          done_nxt       = 1'b1;
        end else begin
          ctr_nxt       = ctr + ADDR_W'(1);
          ram_addr_nxt  = ctr + ADDR_W'(1);
          ram_wdata_nxt = '0;
          ram_write_nxt = 1'b1;
        end
      end

      ST_WRITE: begin
        state_nxt = ST_IDLE;
      end

      ST_RD_ISSUE: begin
        if (stop) begin
          state_nxt = ST_IDLE;
        end else begin
          state_nxt = ST_RD_WAIT;
          tmr_load  = 1'b1;
          tmr_val   = WAIT_LOAD;
        end
      end

      ST_RD_WAIT: begin
        if (stop) begin
          state_nxt = ST_IDLE;
        end else if (tmr_tc) begin
          state_nxt      = ST_DWELL;
          disp_addr_nxt  = ctr;
          disp_data_nxt  = ram_rdata;
          disp_valid_nxt = 1'b1;
          tmr_load       = 1'b1;
          tmr_val        = DWELL_LOAD;
        end
      end

      ST_DWELL: begin
        if (stop) begin
          state_nxt = ST_IDLE;
        end else if (tmr_tc) begin
          // ctr is ADDR_W bits wide, so the loop case wraps 31 -> 0 here
          if ((ctr != LAST_ADDR) || loop) begin
            state_nxt    = ST_RD_ISSUE;
            ctr_nxt      = ctr + ADDR_W'(1);
            ram_addr_nxt = ctr + ADDR_W'(1);
          end else begin
            state_nxt = ST_IDLE;
            done_nxt  = 1'b1;
          end
        end
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, address counter and output registers; reset clears everything
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      ctr        <= '0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
      ram_write  <= 1'b0;
      disp_addr  <= '0;
      disp_data  <= '0;
      disp_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_nxt;
      ctr        <= ctr_nxt;
      ram_addr   <= ram_addr_nxt;
      ram_wdata  <= ram_wdata_nxt;
      ram_write  <= ram_write_nxt;
      disp_addr  <= disp_addr_nxt;
      disp_data  <= disp_data_nxt;
      disp_valid <= disp_valid_nxt;
      busy       <= (state_nxt != ST_IDLE);
      done       <= done_nxt;
    end
  end

endmodule

// File: tb/tb_ram32x4_scan_master.sv
// Bench for ram32x4_scan_master with DWELL=4, RD_LAT=2 and a behavioural
// registered-input RAM. Scan results are checked through a scoreboard queue.
module tb_ram32x4_scan_master;

  localparam int DEPTH  = 32;
  localparam int RD_LAT = 2;
  localparam int DWELL  = 4;
  localparam int CADENCE = 1 + (RD_LAT - 1) + DWELL;

  logic       clk = 1'b0;
  logic       reset, start_scan, loop, stop, clear_req, wr_req;
  logic [4:0] wr_addr;
  logic [3:0] wr_data;
  logic [4:0] ram_addr;
  logic [3:0] ram_wdata;
  logic       ram_write;
  logic [3:0] ram_rdata;
  logic [4:0] disp_addr;
  logic [3:0] disp_data;
  logic       disp_valid, busy, done;

  typedef struct packed {
    logic [4:0] addr;
    logic [3:0] data;
  } scan_exp_t;

  scan_exp_t  sb[$];
  logic [3:0] model_mem [DEPTH];
  logic [3:0] ram_mem [DEPTH];
  logic [4:0] ram_addr_q;
  int         total = 0;
  int         bad = 0;

  always #5 clk = ~clk;

  ram32x4_scan_master #(
    .RD_LAT (RD_LAT),
    .DWELL  (DWELL)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start_scan (start_scan),
    .loop       (loop),
    .stop       (stop),
    .clear_req  (clear_req),
    .wr_req     (wr_req),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .ram_write  (ram_write),
    .ram_rdata  (ram_rdata),
    .disp_addr  (disp_addr),
    .disp_data  (disp_data),
    .disp_valid (disp_valid),
    .busy       (busy),
    .done       (done)
  );

  // Behavioural RAM: address and write registered, read from the registered address
  always @(posedge clk) begin
    if (ram_write) ram_mem[ram_addr] <= ram_wdata;
    ram_addr_q <= ram_addr;
  end
  assign ram_rdata = ram_mem[ram_addr_q];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; start_scan = 1'b0; loop = 1'b0; stop = 1'b0;
    clear_req = 1'b0; wr_req = 1'b0; wr_addr = '0; wr_data = '0;
    repeat (3) tick();
    total++;
    if ({ram_addr, ram_wdata, ram_write, disp_addr, disp_data, disp_valid, busy, done} !== 22'd0) begin
      bad++;
      $display("FAIL reset_outputs got=%h exp=0",
               {ram_addr, ram_wdata, ram_write, disp_addr, disp_data, disp_valid, busy, done});
    end
    reset = 1'b0;
    tick();
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || ram_write !== 1'b0) begin
      bad++;
      $display("FAIL reset_idle got busy=%b done=%b wr=%b exp 0 0 0", busy, done, ram_write);
    end
  endtask

  task automatic test_clear();
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      total++;
      if (ram_write !== 1'b1 || ram_addr !== 5'(i) || ram_wdata !== 4'd0 || busy !== 1'b1 || done !== 1'b0) begin
        bad++;
        $display("FAIL clear_step%0d got wr=%b addr=%0d wdata=%0d busy=%b done=%b exp 1 %0d 0 1 0",
                 i, ram_write, ram_addr, ram_wdata, busy, done, i);
      end
      tick();
    end
    total++;
    if (ram_write !== 1'b0 || done !== 1'b1 || disp_valid !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL clear_end got wr=%b done=%b dvalid=%b busy=%b exp 0 1 0 0",
               ram_write, done, disp_valid, busy);
    end
    tick();
    total++;
    if (done !== 1'b0) begin
      bad++;
      $display("FAIL clear_done_pulse got done=%b exp 0", done);
    end
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 4'd0;
  endtask

  task automatic test_write(input logic [4:0] a, input logic [3:0] d);
    wr_addr = a; wr_data = d; wr_req = 1'b1;
    tick();
    wr_req = 1'b0; wr_addr = ~a; wr_data = ~d;
    total++;
    if (ram_write !== 1'b1 || ram_addr !== a || ram_wdata !== d || busy !== 1'b1) begin
      bad++;
      $display("FAIL write_strobe got wr=%b addr=%0d wdata=%0d busy=%b exp 1 %0d %0d 1",
               ram_write, ram_addr, ram_wdata, busy, a, d);
    end
    tick();
    total++;
    if (ram_write !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL write_end got wr=%b busy=%b done=%b exp 0 0 0", ram_write, busy, done);
    end
    model_mem[a] = d;
  endtask

  // Start a scan and follow n_cap captures; ends right after the last capture
  task automatic run_scan(input logic lp, input int n_cap);
    scan_exp_t e;
    logic [4:0] prev_addr;
    loop = lp;
    start_scan = 1'b1;
    for (int k = 0; k < n_cap; k++) begin
      e.addr = 5'(k % DEPTH);
      e.data = model_mem[k % DEPTH];
      sb.push_back(e);
    end
    tick();
    start_scan = 1'b0;
    total++;
    if (busy !== 1'b1 || ram_addr !== 5'd0 || ram_write !== 1'b0) begin
      bad++;
      $display("FAIL scan_issue got busy=%b addr=%0d wr=%b exp 1 0 0", busy, ram_addr, ram_write);
    end
    prev_addr = '0;
    for (int k = 0; k < n_cap; k++) begin
      int wait_n;
      wait_n = (k == 0) ? RD_LAT : CADENCE;
      for (int c = 0; c < wait_n; c++) begin
        if (k > 0 && c == wait_n - 1) begin
          total++;
          if (disp_addr !== prev_addr) begin
            bad++;
            $display("FAIL scan_hold got disp_addr=%0d exp %0d", disp_addr, prev_addr);
          end
        end
        tick();
        total++;
        if (done !== 1'b0 || ram_write !== 1'b0 || busy !== 1'b1) begin
          bad++;
          $display("FAIL scan_ctrl k=%0d got done=%b wr=%b busy=%b exp 0 0 1", k, done, ram_write, busy);
        end
      end
      e = sb.pop_front();
      total++;
      if (disp_addr !== e.addr || disp_data !== e.data || disp_valid !== 1'b1) begin
        bad++;
        $display("FAIL scan_capture k=%0d got addr=%0d data=%h valid=%b exp %0d %h 1",
                 k, disp_addr, disp_data, disp_valid, e.addr, e.data);
      end
      prev_addr = e.addr;
    end
  endtask

  task automatic test_scan_once();
    run_scan(1'b0, DEPTH);
    for (int c = 0; c < DWELL - 1; c++) begin
      tick();
      total++;
      if (done !== 1'b0 || busy !== 1'b1) begin
        bad++;
        $display("FAIL scan_tail got done=%b busy=%b exp 0 1", done, busy);
      end
    end
    tick();
    total++;
    if (done !== 1'b1 || busy !== 1'b0 || disp_valid !== 1'b1 || disp_addr !== 5'd31) begin
      bad++;
      $display("FAIL scan_done got done=%b busy=%b valid=%b addr=%0d exp 1 0 1 31",
               done, busy, disp_valid, disp_addr);
    end
    tick();
    total++;
    if (done !== 1'b0 || disp_valid !== 1'b1) begin
      bad++;
      $display("FAIL scan_after got done=%b valid=%b exp 0 1", done, disp_valid);
    end
  endtask

  task automatic test_scan_loop();
    test_write(5'd31, 4'hF);
    run_scan(1'b1, DEPTH + 2);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || disp_addr !== 5'd1) begin
      bad++;
      $display("FAIL loop_stop got busy=%b done=%b addr=%0d exp 0 0 1", busy, done, disp_addr);
    end
  endtask

  task automatic test_stop();
    run_scan(1'b0, 8);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || disp_addr !== 5'd7 || disp_valid !== 1'b1) begin
      bad++;
      $display("FAIL stop_dwell got busy=%b done=%b addr=%0d valid=%b exp 0 0 7 1",
               busy, done, disp_addr, disp_valid);
    end
    for (int c = 0; c < CADENCE; c++) begin
      tick();
      total++;
      if (busy !== 1'b0 || done !== 1'b0 || disp_addr !== 5'd7) begin
        bad++;
        $display("FAIL stop_hold got busy=%b done=%b addr=%0d exp 0 0 7", busy, done, disp_addr);
      end
    end
  endtask

  task automatic test_priority();
    wr_addr = 5'd3; wr_data = 4'd6;
    clear_req = 1'b1; wr_req = 1'b1; start_scan = 1'b1;
    tick();
    clear_req = 1'b0; wr_req = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (i == 20) start_scan = 1'b0;
      total++;
      if (ram_write !== 1'b1 || ram_addr !== 5'(i) || ram_wdata !== 4'd0 || busy !== 1'b1) begin
        bad++;
        $display("FAIL prio_clear%0d got wr=%b addr=%0d wdata=%0d busy=%b exp 1 %0d 0 1",
                 i, ram_write, ram_addr, ram_wdata, busy, i);
      end
      tick();
    end
    total++;
    if (done !== 1'b1 || disp_valid !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL prio_end got done=%b valid=%b busy=%b exp 1 0 0", done, disp_valid, busy);
    end
    tick();
    total++;
    if (busy !== 1'b0 || ram_write !== 1'b0) begin
      bad++;
      $display("FAIL prio_no_queue got busy=%b wr=%b exp 0 0", busy, ram_write);
    end
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 4'd0;
  endtask

  task automatic test_reset_mid_clear();
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    repeat (10) tick();
    total++;
    if (ram_write !== 1'b1 || ram_addr !== 5'd10) begin
      bad++;
      $display("FAIL rst_clear_pre got wr=%b addr=%0d exp 1 10", ram_write, ram_addr);
    end
    reset = 1'b1;
    tick();
    total++;
    if (ram_write !== 1'b0 || busy !== 1'b0 || ram_addr !== 5'd0 || done !== 1'b0) begin
      bad++;
      $display("FAIL rst_clear_cut got wr=%b busy=%b addr=%0d done=%b exp 0 0 0 0",
               ram_write, busy, ram_addr, done);
    end
    reset = 1'b0;
    tick();
    total++;
    if (ram_write !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL rst_clear_idle got wr=%b busy=%b exp 0 0", ram_write, busy);
    end
  endtask

  initial begin
    test_reset();
    test_clear();
    test_write(5'd5, 4'd9);
    test_scan_once();
    test_scan_loop();
    test_stop();
    test_priority();
    test_reset_mid_clear();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
